// File: rtl/gpio_event_device.sv
// Banked GPIO device: per-pin direction/output registers, synchronised and
// debounced inputs, edge capture into W1C pending flags, level interrupt.
module gpio_event_device #(
  parameter int PINS           = 7,
  parameter int DEVICE_ID      = 4,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic             cpu_clock,
  input  logic             reset,
  input  logic             write_enable,
  input  logic             is_control,
  input  logic [7:0]       short_address,
  input  logic [15:0]      cpu_data_in,
  output logic [15:0]      cpu_data_out,
  input  logic [PINS-1:0]  gpio_in,
  output logic [PINS-1:0]  gpio_out,
  output logic [PINS-1:0]  gpio_config,
  output logic             irq
);

  localparam int NBANKS = (PINS + 15) / 16;
  localparam int W      = NBANKS * 16;

  logic [PINS-1:0]           gpioOut_q, gpioOut_d;
  logic [PINS-1:0]           gpioConfig_q, gpioConfig_d;
  logic [PINS-1:0]           riseEn_q, riseEn_d;
  logic [PINS-1:0]           fallEn_q, fallEn_d;
  logic [PINS-1:0]           pending_q, pending_d;
  logic [PINS-1:0]           sync1_q, sync2_q;
  logic [PINS-1:0]           sample_q, sample_d;
  logic [PINS-1:0]           debounced_q, debounced_d;
  logic [PINS-1:0]           debPrev_q;
  logic [DEBOUNCE_WIDTH-1:0] reload_q, reload_d;
  logic [DEBOUNCE_WIDTH-1:0] presc_q, presc_d;
  logic                      irq_q;
  logic [15:0]               rdata_d, rdata_q;

  logic [3:0]      addrClass, bank;
  logic            bankValid, memWrite, reloadWrite, tick;
  logic [W-1:0]    bankMask, wdataW;
  logic [PINS-1:0] clearMask, riseEvt, fallEvt, agree;

  assign addrClass   = short_address[7:4];
  assign bank        = short_address[3:0];
  assign bankValid   = (32'(bank) < NBANKS);
  assign memWrite    = write_enable & ~is_control & bankValid;
  assign reloadWrite = write_enable & is_control & (short_address == 8'h02);
  assign bankMask    = W'(16'hFFFF) << {bank, 4'b0000};
  assign wdataW      = W'(cpu_data_in) << {bank, 4'b0000};
  assign tick        = (reload_q != '0) && (presc_q == '0);

  function automatic logic [PINS-1:0] mergeBank(input logic [PINS-1:0] cur,
                                                input logic [W-1:0]    data,
                                                input logic [W-1:0]    mask);
    return PINS'((W'(cur) & ~mask) | (data & mask));
  endfunction

  function automatic logic [15:0] bankSlice(input logic [PINS-1:0] v,
                                            input logic [3:0]      b);
    logic [W-1:0] wide;
    wide = W'(v) >> {b, 4'b0000};
    return wide[15:0];
  endfunction

  always_comb begin
    gpioOut_d    = gpioOut_q;
    gpioConfig_d = gpioConfig_q;
    riseEn_d     = riseEn_q;
    fallEn_d     = fallEn_q;
    clearMask    = '0;
    if (memWrite) begin
      case (addrClass)
        4'h1: gpioOut_d    = mergeBank(gpioOut_q, wdataW, bankMask);
        4'h2: gpioConfig_d = mergeBank(gpioConfig_q, wdataW, bankMask);
        4'h3: riseEn_d     = mergeBank(riseEn_q, wdataW, bankMask);
        4'h4: fallEn_d     = mergeBank(fallEn_q, wdataW, bankMask);
        4'h5: clearMask    = PINS'(wdataW & bankMask);
        default: ;
      endcase
    end

    // New events are OR-ed in after the clear so a coincident set survives
    riseEvt   = debounced_q & ~debPrev_q & riseEn_q;
    fallEvt   = ~debounced_q & debPrev_q & fallEn_q;
    pending_d = (pending_q & ~clearMask) | riseEvt | fallEvt;

    reload_d = reloadWrite ? DEBOUNCE_WIDTH'(cpu_data_in) : reload_q;
    if (reloadWrite)            presc_d = DEBOUNCE_WIDTH'(cpu_data_in);
    else if (reload_q == '0)    presc_d = '0;
    else if (presc_q == '0)     presc_d = reload_q;
    else                        presc_d = presc_q - DEBOUNCE_WIDTH'(1);

    // A pin follows its sample only when two consecutive ticks agree
    agree       = ~(sync2_q ^ sample_q);
    sample_d    = sample_q;
    debounced_d = debounced_q;
    if (reload_q == '0) begin
      sample_d    = sync2_q;
      debounced_d = sync2_q;
    end else if (tick) begin
      sample_d    = sync2_q;
      debounced_d = (agree & sync2_q) | (~agree & debounced_q);
    end

    rdata_d = '0;
    if (is_control) begin
      case (short_address)
        8'h00:   rdata_d = {8'(DEVICE_ID), 8'h01};
        8'h01:   rdata_d = 16'(PINS);
        8'h02:   rdata_d = 16'(reload_q);
        8'h03:   rdata_d = {15'b0, irq_q};
        default: rdata_d = '0;
      endcase
    end else if (bankValid) begin
      case (addrClass)
        4'h0:    rdata_d = bankSlice(debounced_q, bank);
        4'h1:    rdata_d = bankSlice(gpioOut_q, bank);
        4'h2:    rdata_d = bankSlice(gpioConfig_q, bank);
        4'h3:    rdata_d = bankSlice(riseEn_q, bank);
        4'h4:    rdata_d = bankSlice(fallEn_q, bank);
        4'h5:    rdata_d = bankSlice(pending_q, bank);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      gpioOut_q    <= '0;
      gpioConfig_q <= '0;
      riseEn_q     <= '0;
      fallEn_q     <= '0;
      pending_q    <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_q     <= '0;
      debounced_q  <= '0;
      debPrev_q    <= '0;
      reload_q     <= '0;
      presc_q      <= '0;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      gpioOut_q    <= gpioOut_d;
      gpioConfig_q <= gpioConfig_d;
      riseEn_q     <= riseEn_d;
      fallEn_q     <= fallEn_d;
      pending_q    <= pending_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      sample_q     <= sample_d;
      debounced_q  <= debounced_d;
      debPrev_q    <= debounced_q;
      reload_q     <= reload_d;
      presc_q      <= presc_d;
      irq_q        <= |pending_q;
      rdata_q      <= rdata_d;
    end
  end

  assign cpu_data_out = rdata_q;
  assign gpio_out     = gpioOut_q;
  assign gpio_config  = gpioConfig_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_event_device.sv
// Bench for gpio_event_device: a 7-pin and a 20-pin instance share one bus;
// expectations come from register/bank arithmetic and input delay history.
module tb_gpio_event_device;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic        is_control;
  logic [7:0]  short_address;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out, cpu_data_out20;
  logic [6:0]  gpio_in, gpio_out, gpio_config;
  logic [19:0] gpio_in20, gpio_out20, gpio_config20;
  logic        irq, irq20;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] model7  [0:5][0:2];
  logic [15:0] model20 [0:5][0:2];

  gpio_event_device #(.PINS(7)) u_dut (
    .cpu_clock(clock), .reset(reset), .write_enable(write_enable),
    .is_control(is_control), .short_address(short_address),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_config(gpio_config),
    .irq(irq)
  );

  gpio_event_device #(.PINS(20)) u_dut20 (
    .cpu_clock(clock), .reset(reset), .write_enable(write_enable),
    .is_control(is_control), .short_address(short_address),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out20),
    .gpio_in(gpio_in20), .gpio_out(gpio_out20), .gpio_config(gpio_config20),
    .irq(irq20)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bus write, committed at the edge after the signals are set up
  task automatic applyStimulus(input logic ctrl, input logic [7:0] addr,
                               input logic [15:0] data);
    @(posedge clock); #1;
    write_enable  = 1'b1;
    is_control    = ctrl;
    short_address = addr;
    cpu_data_in   = data;
    @(posedge clock); #1;
    write_enable  = 1'b0;
  endtask

  task automatic readBus(input logic ctrl, input logic [7:0] addr,
                         output logic [15:0] d7, output logic [15:0] d20);
    @(posedge clock); #1;
    is_control    = ctrl;
    short_address = addr;
    @(posedge clock); #1;
    d7  = cpu_data_out;
    d20 = cpu_data_out20;
  endtask

  function automatic logic [15:0] validMask(input int pins, input int bank);
    int live;
    live = pins - bank * 16;
    if (live <= 0)  return 16'h0000;
    if (live >= 16) return 16'hFFFF;
    return 16'((32'd1 << live) - 1);
  endfunction

  initial begin
    logic [15:0] r7, r20, data;
    logic [6:0]  hist[$];
    logic [6:0]  v;
    int cls, bank;

    reset = 1'b1; write_enable = 1'b0; is_control = 1'b0;
    short_address = '0; cpu_data_in = '0; gpio_in = '0; gpio_in20 = '0;
    for (int c = 0; c < 6; c++)
      for (int b = 0; b < 3; b++) begin
        model7[c][b]  = '0;
        model20[c][b] = '0;
      end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("reset_gpio_out", 32'(gpio_out), 32'h0);
    checkOutput("reset_rdata", 32'(cpu_data_out), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);

    // Reset arriving in the middle of a pending write
    applyStimulus(1'b0, 8'h20, 16'h007F);
    @(posedge clock); #1;
    checkOutput("pre_reset_config_read", 32'(cpu_data_out), 32'h007F);
    write_enable = 1'b1; is_control = 1'b0;
    short_address = 8'h10; cpu_data_in = 16'hFFFF;
    #3 reset = 1'b1;
    #1;
    checkOutput("midreset_gpio_out", 32'(gpio_out), 32'h0);
    checkOutput("midreset_config", 32'(gpio_config), 32'h0);
    checkOutput("midreset_rdata", 32'(cpu_data_out), 32'h0);
    checkOutput("midreset_irq", 32'(irq), 32'h0);
    @(posedge clock); #1;
    write_enable = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("write_lost_in_reset", 32'(gpio_out), 32'h0);
    readBus(1'b1, 8'h00, r7, r20);
    checkOutput("ctrl_id", 32'(r7), 32'h0401);
    checkOutput("ctrl_id20", 32'(r20), 32'h0401);

    applyStimulus(1'b0, 8'h10, 16'h0055);
    applyStimulus(1'b0, 8'h20, 16'h007F);
    model7[1][0] = 16'h0055; model7[2][0] = 16'h007F;
    model20[1][0] = 16'h0055; model20[2][0] = 16'h007F;
    readBus(1'b0, 8'h10, r7, r20);
    checkOutput("read_out", 32'(r7), 32'h0055);
    readBus(1'b0, 8'h20, r7, r20);
    checkOutput("read_config", 32'(r7), 32'h007F);
    checkOutput("gpio_out_port", 32'(gpio_out), 32'h55);

    // Random register traffic against per-bank masked models
    for (int i = 0; i < 16; i++) begin
      cls  = $urandom_range(1, 4);
      bank = $urandom_range(0, 2);
      data = 16'($urandom);
      applyStimulus(1'b0, 8'(cls * 16 + bank), data);
      model7[cls][bank]  = data & validMask(7, bank);
      model20[cls][bank] = data & validMask(20, bank);
      readBus(1'b0, 8'(cls * 16 + bank), r7, r20);
      checkOutput($sformatf("rand_reg7_c%0d_b%0d", cls, bank), 32'(r7), 32'(model7[cls][bank]));
      checkOutput($sformatf("rand_reg20_c%0d_b%0d", cls, bank), 32'(r20), 32'(model20[cls][bank]));
    end
    checkOutput("rand_out_port", 32'(gpio_out), 32'(model7[1][0][6:0]));
    checkOutput("rand_config_port", 32'(gpio_config), 32'(model7[2][0][6:0]));
    checkOutput("rand_out20_port", 32'(gpio_out20), {12'b0, model20[1][1][3:0], model20[1][0]});
    applyStimulus(1'b0, 8'h30, 16'h0000);
    applyStimulus(1'b0, 8'h40, 16'h0000);
    applyStimulus(1'b0, 8'h31, 16'h0000);
    applyStimulus(1'b0, 8'h41, 16'h0000);
    checkOutput("rand_irq_quiet", 32'(irq), 32'h0);

    // Bypass debounce: read value equals the pins driven four edges earlier
    readBus(1'b0, 8'h00, r7, r20);
    for (int i = 0; i < 4; i++) hist.push_back(7'h00);
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("bypass_in_%0d", i), 32'(cpu_data_out), 32'(hist[hist.size() - 4]));
      v = 7'($urandom);
      gpio_in = v;
      hist.push_back(v);
    end
    gpio_in = '0;
    repeat (6) @(posedge clock);
    applyStimulus(1'b0, 8'h50, 16'hFFFF);

    // Rising edge on pin0 with bypass debounce
    applyStimulus(1'b0, 8'h30, 16'h0001);
    readBus(1'b0, 8'h00, r7, r20);
    checkOutput("pin0_low", 32'(r7), 32'h0);
    gpio_in = 7'h01;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      if (k == 3) checkOutput("pin0_deb_not_yet", 32'(cpu_data_out), 32'h0000);
      if (k == 4) begin
        checkOutput("pin0_deb_high", 32'(cpu_data_out), 32'h0001);
        checkOutput("pin0_irq_not_yet", 32'(irq), 32'h0);
      end
      if (k == 5) checkOutput("pin0_irq", 32'(irq), 32'h1);
    end
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("pin0_pending", 32'(r7), 32'h0001);
    readBus(1'b1, 8'h03, r7, r20);
    checkOutput("ctrl_irq", 32'(r7), 32'h0001);
    applyStimulus(1'b0, 8'h50, 16'h0001);
    @(posedge clock); #1;
    checkOutput("pin0_irq_cleared", 32'(irq), 32'h0);
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("pin0_pending_cleared", 32'(r7), 32'h0000);

    // Reload 3: a one-cycle glitch must not pass, a held level must
    applyStimulus(1'b0, 8'h30, 16'h0003);
    applyStimulus(1'b1, 8'h02, 16'h0003);
    readBus(1'b1, 8'h02, r7, r20);
    checkOutput("reload_read", 32'(r7), 32'h0003);
    readBus(1'b0, 8'h00, r7, r20);
    gpio_in = 7'h03;
    @(posedge clock); #1;
    gpio_in = 7'h01;
    repeat (12) @(posedge clock);
    #1;
    checkOutput("glitch_deb", 32'(cpu_data_out), 32'h0001);
    checkOutput("glitch_irq", 32'(irq), 32'h0);
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("glitch_pending", 32'(r7), 32'h0000);
    readBus(1'b0, 8'h00, r7, r20);
    gpio_in = 7'h03;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (k == 7)  checkOutput("hold_deb_early", 32'(cpu_data_out), 32'h0001);
      if (k == 12) checkOutput("hold_deb_late", 32'(cpu_data_out), 32'h0003);
    end
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("hold_pending", 32'(r7), 32'h0002);
    applyStimulus(1'b0, 8'h50, 16'hFFFF);

    // W1C landing on the same edge as a new falling-edge event on pin2
    applyStimulus(1'b1, 8'h02, 16'h0000);
    applyStimulus(1'b0, 8'h40, 16'h0004);
    gpio_in = 7'h07;
    repeat (6) @(posedge clock);
    applyStimulus(1'b0, 8'h50, 16'hFFFF);
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("w1c_pre_clear", 32'(r7), 32'h0000);
    gpio_in = 7'h03;
    repeat (2) @(posedge clock);
    applyStimulus(1'b0, 8'h50, 16'h0004);
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("w1c_set_wins", 32'(r7), 32'h0004);
    checkOutput("w1c_irq", 32'(irq), 32'h1);
    applyStimulus(1'b0, 8'h50, 16'h0004);
    readBus(1'b0, 8'h50, r7, r20);
    checkOutput("w1c_later_clear", 32'(r7), 32'h0000);
    checkOutput("w1c_irq_clear", 32'(irq), 32'h0);

    // Bank boundaries on both instances
    readBus(1'b1, 8'h01, r7, r20);
    checkOutput("ctrl_pins7", 32'(r7), 32'd7);
    checkOutput("ctrl_pins20", 32'(r20), 32'd20);
    readBus(1'b0, 8'h60, r7, r20);
    checkOutput("class6_zero", 32'(r7), 32'h0);
    readBus(1'b1, 8'h07, r7, r20);
    checkOutput("ctrl_other_zero", 32'(r7), 32'h0);
    applyStimulus(1'b0, 8'h11, 16'hFFFF);
    applyStimulus(1'b0, 8'h12, 16'hFFFF);
    readBus(1'b0, 8'h11, r7, r20);
    checkOutput("bank1_pins7", 32'(r7), 32'h0000);
    checkOutput("bank1_pins20", 32'(r20), 32'h000F);
    readBus(1'b0, 8'h12, r7, r20);
    checkOutput("bank2_pins20", 32'(r20), 32'h0000);
    checkOutput("bank1_out20_port", 32'(gpio_out20[19:16]), 32'hF);
    checkOutput("bank1_out7_unchanged", 32'(gpio_out), 32'(model7[1][0][6:0]));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/gpio_event_device.md
Name: gpio_event_device

Overview:
Parametrised successor to the fixed 7-pin GPIO device on the CPU device bus. Provides up to 64 pins with per-pin direction and output registers, a two-flop input synchroniser and a shared-tick debouncer. Adds rising/falling edge capture with write-1-to-clear pending flags and a level interrupt. Decoded in the top level by device_id, exactly like existing devices, with a registered read path.

Parameters:
PINS, 7, number of GPIO pins, 1..64; unused bits of the top bank read 0 and ignore writes.
DEVICE_ID, 4, device id reported in the control page.
DEBOUNCE_WIDTH, 16, width of the debounce prescaler and its reload register.

Ports:
cpu_clock  input  1  single system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
write_enable  input  1  bus write strobe, already qualified by device_id in the top level.
is_control  input  1  1 = control page access, 0 = memory page access.
short_address  input  8  register address within the page.
cpu_data_in  input  16  write data from the CPU.
cpu_data_out  output  16  registered read data to the CPU.
gpio_in  input  PINS  raw pin inputs, asynchronous.
gpio_out  output  PINS  output value register.
gpio_config  output  PINS  direction register, 1 = drive.
irq  output  1  OR of all pending & enabled events, registered.

Behaviour:
- Reset (async, high): every register, synchroniser, prescaler, pending flag, cpu_data_out and irq go to 0. Effects are immediate; no partial write completes.
- Banks: NBANKS = ceil(PINS/16). Bank b covers pins 16b..16b+15.
- Memory page: short_address[7:4] selects the class; short_address[3:0] is the bank. A bank >= NBANKS reads 0 and ignores writes.
  - Class 0: debounced input value, read-only.
  - Class 1: gpio_out, read/write.
  - Class 2: gpio_config, read/write.
  - Class 3: rise_en, read/write.
  - Class 4: fall_en, read/write.
  - Class 5: pending flags; writing 1 clears a bit, writing 0 leaves it unchanged.
  - Classes 6-F: read 0.
- Control page:
  - 0x00 reads {DEVICE_ID[7:0], 8'h01}.
  - 0x01 reads PINS.
  - 0x02 is debounce_reload (DEBOUNCE_WIDTH bits, read/write, zero-extended).
  - 0x03 reads {15'b0, irq}.
  - Other addresses read 0. Writes to read-only addresses are ignored.
- Read latency: cpu_data_out is updated every cycle from the current address and page, so data is valid 1 cycle after the address is presented. A same-cycle write is not visible until the following read cycle.
- Writes take effect at the rising edge where write_enable=1.
- Synchroniser: two flops per pin, giving sync = gpio_in delayed by 2 cycles.
- Debounce:
  - If debounce_reload == 0, debounced = sync every cycle (bypass).
  - Otherwise the prescaler counts down from reload to 0. At 0 it emits a tick and reloads.
  - On each tick, sample = sync. A pin's debounced bit updates only when sample equals the previous tick's sample, i.e. 2 consecutive agreeing ticks.
  - Writing debounce_reload restarts the prescaler at the new value on the next cycle.
- Edge detect, registered: rise = debounced & ~debounced_prev & rise_en; fall = ~debounced & debounced_prev & fall_en.
  - pending |= rise | fall.
  - If a set and a W1C hit the same bit in the same cycle, the set wins (bit stays 1).
  - Changing the enables never clears pending.
- irq = |pending, registered, so it asserts 1 cycle after pending is set.
- Output pins: gpio_out and gpio_config are driven directly from registers. The input path reads the pin regardless of direction (loopback allowed).

Test Plan:
- Assert reset mid-write of gpio_out=0xFFFF -> gpio_out, gpio_config, cpu_data_out and irq read 0 immediately. Control 0x00 reads 0x0401 one cycle after addressing.
- Write mem 0x10=0x0055 and 0x20=0x007F, then read both -> cpu_data_out=0x0055 and 0x007F one cycle later. gpio_out[6:0]=7'h55.
- Reload=0, rise_en=0x0001, pin0 0->1 -> debounced bit0=1 after 3 cycles, pending bit0=1, irq=1 one cycle later. Write 0x0001 to 0x50 -> pending=0, irq=0.
- Reload=3, 1-cycle glitch on pin1 -> debounced unchanged, no pending. A level held for 8+ cycles -> debounced changes after the second agreeing tick.
- W1C to 0x50 in the same cycle as a new falling edge on pin2 with fall_en=0x0004 -> pending bit2 stays 1.
- PINS=20: bank 1 bits 3:0 are live and bits 15:4 read 0. Access to bank 2 (0x12) reads 0 and writes have no effect.
